// File: rtl/dm_access_ctrl_pkg.sv
// Shared state encoding and default geometry for the data-memory access controller.
package dm_pkg;

    localparam int DM_ADDR_W  = 16;
    localparam int DM_DATA_W  = 16;
    localparam int DM_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Request/memory bundle between control unit, memory and the access controller.
interface dm_access_ctrl_if #(
    parameter int ADDR_W = dm_pkg::DM_ADDR_W,
    parameter int DATA_W = dm_pkg::DM_DATA_W
);
    logic [ADDR_W-1:0] DMADDR;
    logic [DATA_W-1:0] DIN;
    logic              rd_req;
    logic              wr_req;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_en;
    logic              mem_we;
    logic [DATA_W-1:0] DMOUT;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output DMADDR, DIN, rd_req, wr_req, mem_rdata, mem_ready,
        input  mem_addr, mem_wdata, mem_en, mem_we, DMOUT, busy, done, err
    );

    modport slave (
        input  DMADDR, DIN, rd_req, wr_req, mem_rdata, mem_ready,
        output mem_addr, mem_wdata, mem_en, mem_we, DMOUT, busy, done, err
    );
endinterface

// File: rtl/dm_timeout_cnt.sv
// Counts ACCESS cycles without mem_ready; expired fires on the cycle the count would reach TIMEOUT.
// Latency: expired is combinational from the current count and inc; no backpressure.
module dm_timeout_cnt #(
    parameter int TIMEOUT = dm_pkg::DM_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (inc) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expired = inc && (cnt == LIMIT);

endmodule

// File: rtl/dm_access_ctrl.sv
// Single-outstanding data-memory read/write sequencer; optional abort via DM_TIMEOUT_EN.
// Latency: request at edge N -> mem_en in N+1 -> done in N+2 at best; requests while busy are dropped.
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int ADDR_W  = DM_ADDR_W,
    parameter int DATA_W  = DM_DATA_W,
    parameter int TIMEOUT = DM_TIMEOUT
) (
    input logic              clk,
    input logic              rst_n,
    dm_access_ctrl_if.slave  bus
);
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("dm_access_ctrl: TIMEOUT must be in 1..255");
    end

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] dmout_q;
    logic              en_q;
    logic              we_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              req;
    logic              to_hit;

    assign req = bus.rd_req | bus.wr_req;

`ifdef DM_TIMEOUT_EN
    dm_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     ((state == IDLE) && req),
        .inc     ((state == ACCESS) && !bus.mem_ready),
        .expired (to_hit)
    );
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            dmout_q <= '0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (req) begin
                        addr_q  <= bus.DMADDR;
                        wdata_q <= bus.DIN;
                        we_q    <= bus.wr_req;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // mem_ready outranks an expiring timeout in the same cycle
                    if (bus.mem_ready || to_hit) begin
                        en_q   <= 1'b0;
                        we_q   <= 1'b0;
                        done_q <= 1'b1;
                        err_q  <= !bus.mem_ready;
                        state  <= DONE;
                        if (bus.mem_ready && !we_q) begin
                            dmout_q <= bus.mem_rdata;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    en_q   <= 1'b0;
                    we_q   <= 1'b0;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_en    = en_q;
    assign bus.mem_we    = we_q;
    assign bus.DMOUT     = dmout_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: doc/dm_access_ctrl.md
DM_ACCESS_CTRL -- requirements
Module: dm_access_ctrl

Interface
REQ-001 Parameter ADDR_W, 16, width of the data-memory address.
REQ-002 Parameter DATA_W, 16, width of the data-memory word.
REQ-003 Parameter TIMEOUT, 15, maximum ACCESS cycles without mem_ready before abort (1..255).
REQ-004 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port DMADDR  input  ADDR_W  address from the AR register.
REQ-007 Port DIN  input  DATA_W  write data from the data register.
REQ-008 Port rd_req  input  1  read request from the control unit.
REQ-009 Port wr_req  input  1  write request from the control unit.
REQ-010 Port mem_rdata  input  DATA_W  read data from the memory.
REQ-011 Port mem_ready  input  1  memory completion strobe.
REQ-012 Port mem_addr  output  ADDR_W  registered address to the memory.
REQ-013 Port mem_wdata  output  DATA_W  registered write data to the memory.
REQ-014 Port mem_en  output  1  memory access enable.
REQ-015 Port mem_we  output  1  memory write enable; 1 = write.
REQ-016 Port DMOUT  output  DATA_W  last read word, driven toward the bus.
REQ-017 Port busy  output  1  high in any state other than IDLE.
REQ-018 Port done  output  1  one-cycle completion pulse.
REQ-019 Port err  output  1  timeout flag for the access that just completed.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-021 In IDLE, a sampled rd_req or wr_req SHALL capture DMADDR into mem_addr and DIN into mem_wdata, then move the FSM to ACCESS.
REQ-022 If rd_req and wr_req are both high in IDLE, write SHALL win: mem_we=1.
REQ-023 Requests arriving in ACCESS or DONE SHALL be ignored and not queued.
REQ-024 In ACCESS, mem_en SHALL be 1 and mem_addr, mem_wdata and mem_we SHALL stay stable.
REQ-025 In ACCESS with mem_ready=1, the FSM SHALL move to DONE; on a read, mem_rdata SHALL be registered into DMOUT on that same edge.
REQ-026 In DONE, done SHALL be 1 for exactly one cycle, mem_en SHALL be 0, and the next state SHALL be IDLE.
REQ-027 Minimum latency SHALL be: request sampled at edge N, mem_en high in cycle N+1, done high in cycle N+2 when mem_ready is already high.
REQ-028 DMOUT SHALL change only on a completed read; writes and timeouts leave it unchanged.
REQ-029 err SHALL be updated on entry to DONE (1 on timeout, 0 otherwise) and held until the next entry to DONE.
REQ-030 mem_we SHALL be 0 whenever mem_en is 0.

Reset
REQ-031 On rst_n low, the block SHALL go to IDLE immediately, without waiting for clk.
REQ-032 During reset, mem_addr=0, mem_wdata=0, mem_en=0, mem_we=0, DMOUT=0, busy=0, done=0 and err=0.
REQ-033 A reset during ACCESS SHALL abort the access: no done pulse, DMOUT unchanged from its reset value.
REQ-034 Release of rst_n SHALL be followed by normal operation, with a request accepted at the first rising clk edge after release.

Configuration
REQ-035 With macro DM_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle without mem_ready.
REQ-036 With DM_TIMEOUT_EN defined, reaching TIMEOUT SHALL force DONE with err=1, and mem_ready in that same cycle SHALL take priority (normal completion).
REQ-037 Without DM_TIMEOUT_EN, ACCESS SHALL wait for mem_ready indefinitely, err SHALL be tied 0, and no counter logic SHALL be present.

Structure
REQ-038 Package dm_pkg SHALL hold the state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and the ADDR_W, DATA_W and TIMEOUT defaults.
REQ-039 The timeout counter SHALL be a sub-module named dm_timeout_cnt, instantiated only under DM_TIMEOUT_EN; the FSM and datapath stay in dm_access_ctrl.

Verification
REQ-040 Read: DMADDR=16'h00FF, rd_req=1 for one cycle, mem_rdata=16'hA5A5, mem_ready high 2 cycles after mem_en -> mem_addr=16'h00FF, mem_we=0, DMOUT=16'hA5A5, done pulses once, err=0.
REQ-041 Write: DMADDR=16'h00CC, DIN=16'h0EEF, wr_req=1, mem_ready immediately -> mem_we=1, mem_wdata=16'h0EEF, done at N+2, DMOUT unchanged.
REQ-042 Simultaneous: rd_req=wr_req=1 with DMADDR=16'h1234 -> a single write access to 16'h1234; a second wr_req asserted while busy is dropped (one done pulse only).
REQ-043 Timeout (DM_TIMEOUT_EN, TIMEOUT=15): mem_ready held low -> mem_en high for 15 cycles, then done=1, err=1; the next successful access clears err.
REQ-044 Reset mid-access: rst_n low in the 3rd ACCESS cycle -> all outputs 0 asynchronously; no done pulse; a read accepted after release completes normally.
REQ-045 Build without DM_TIMEOUT_EN and mem_ready low for 100 cycles -> busy stays 1, err=0, and completion occurs when mem_ready rises.
